// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Two-port writeback arbiter for the integer register file. Port 0 carries
//   pipeline writebacks and normally has priority; port 1 carries writebacks
//   from a long-latency unit. Once port 1 has been held off for STARVE_LIMIT
//   consecutive cycles, it takes priority until one of its requests goes through.
//   The winning request goes into the regfile write port one cycle later.
//
// Handshake: a transfer on port N happens at a rising clk edge when
//   wbN_valid && wbN_ready. A requester keeps valid/rd/data/pc stable until
//   its transfer. wbN_ready is combinational, is high only for the granted
//   port, and is low on both ports while rstn is low.
//
// Parameters
//   XLEN          data / PC width
//   STARVE_LIMIT  stalled cycles of port 1 before it overrides port 0 (1..15)
//
// Ports
//   clk, rstn                     clock, synchronous active-low reset
//   wb0_* / wb1_*                 writeback request ports (valid, rd, data, pc, ready)
//   scb_set, scb_rd               long-latency op issue: mark rd as pending
//   rf_we, rf_wa, rf_wd, rf_pc    registered regfile write port
//   busy                          registered per-register pending-write vector
//   dbg_state                     arbitration state (0 = NORMAL, 1 = STARVED)
//   dbg_starve_cnt                port 1 starvation counter
//
// Configuration
//   XGRISCV_RF_SCOREBOARD_EN  defined: busy is maintained from scb_set and
//                             port 1 transfers. Undefined: busy is tied to 0
//                             and no scoreboard flops are built.

module rf_wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            wb0_valid,
    input  logic [4:0]      wb0_rd,
    input  logic [XLEN-1:0] wb0_data,
    input  logic [XLEN-1:0] wb0_pc,
    output logic            wb0_ready,
    input  logic            wb1_valid,
    input  logic [4:0]      wb1_rd,
    input  logic [XLEN-1:0] wb1_data,
    input  logic [XLEN-1:0] wb1_pc,
    output logic            wb1_ready,
    input  logic            scb_set,
    input  logic [4:0]      scb_rd,
    output logic            rf_we,
    output logic [4:0]      rf_wa,
    output logic [XLEN-1:0] rf_wd,
    output logic [XLEN-1:0] rf_pc,
    output logic [31:0]     busy,
    output logic            dbg_state,
    output logic [3:0]      dbg_starve_cnt
);

    typedef enum logic {
        ARB_NORMAL  = 1'b0,
        ARB_STARVED = 1'b1
    } arb_state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_t state;
    logic [3:0] starve_cnt;
    logic [3:0] starve_cnt_next;
    logic       grant0;
    logic       grant1;

    // The state register always equals (starve_cnt >= LIMIT). It is updated
    // from the same next-count value, so grant can use it directly.
    always_comb begin
        grant1 = rstn && wb1_valid && (!wb0_valid || state == ARB_STARVED);
        grant0 = rstn && wb0_valid && !grant1;
    end

    assign wb0_ready = grant0;
    assign wb1_ready = grant1;

    // The count clears when port 1 goes idle or completes a transfer.
    // Otherwise port 1 is valid and stalled, so the count rises and saturates.
    always_comb begin
        starve_cnt_next = starve_cnt;
        if (!wb1_valid || grant1) begin
            starve_cnt_next = 4'd0;
        end else if (starve_cnt != 4'hF) begin
            starve_cnt_next = starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= ARB_NORMAL;
            starve_cnt <= 4'd0;
            rf_we      <= 1'b0;
            rf_wa      <= 5'd0;
            rf_wd      <= '0;
            rf_pc      <= '0;
        end else begin
            starve_cnt <= starve_cnt_next;
            state      <= (starve_cnt_next >= LIMIT) ? ARB_STARVED : ARB_NORMAL;
            // A write to x0 is accepted but never reaches the regfile.
            rf_we      <= (grant1 && wb1_rd != 5'd0) || (grant0 && wb0_rd != 5'd0);
            if (grant1) begin
                rf_wa <= wb1_rd;
                rf_wd <= wb1_data;
                rf_pc <= wb1_pc;
            end else if (grant0) begin
                rf_wa <= wb0_rd;
                rf_wd <= wb0_data;
                rf_pc <= wb0_pc;
            end
        end
    end

    assign dbg_state      = state;
    assign dbg_starve_cnt = starve_cnt;

`ifdef XGRISCV_RF_SCOREBOARD_EN
    logic [31:0] busy_q;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (scb_set && scb_rd != 5'd0) begin
            set_mask[scb_rd] = 1'b1;
        end
        if (grant1 && wb1_rd != 5'd0) begin
            clr_mask[wb1_rd] = 1'b1;
        end
    end

    // The set mask is applied after the clear mask, so when both hit the
    // same register in one cycle, the set wins. Bit 0 is masked off.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy_q <= '0;
        end else begin
            busy_q <= ((busy_q & ~clr_mask) | set_mask) & 32'hFFFF_FFFE;
        end
    end

    assign busy = busy_q;
`else
    logic unused_scb;
    assign unused_scb = &{1'b0, scb_set, scb_rd};
    assign busy       = '0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed testbench for rf_wb_arbiter (XLEN=32, STARVE_LIMIT=4).

module tb_rf_wb_arbiter;

    localparam int W = 70;  // {we, wa[4:0], wd[31:0], pc[31:0]}

    logic        clk;
    logic        rstn;
    logic        wb0_valid, wb1_valid, wb0_ready, wb1_ready;
    logic [4:0]  wb0_rd, wb1_rd, scb_rd, rf_wa;
    logic [31:0] wb0_data, wb0_pc, wb1_data, wb1_pc, rf_wd, rf_pc, busy;
    logic        scb_set, rf_we, dbg_state;
    logic [3:0]  dbg_starve_cnt;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    rf_wb_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rstn(rstn),
        .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb0_data(wb0_data),
        .wb0_pc(wb0_pc), .wb0_ready(wb0_ready),
        .wb1_valid(wb1_valid), .wb1_rd(wb1_rd), .wb1_data(wb1_data),
        .wb1_pc(wb1_pc), .wb1_ready(wb1_ready),
        .scb_set(scb_set), .scb_rd(scb_rd),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_pc(rf_pc),
        .busy(busy), .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle. The step is given the grant it expects and checks the
    // ready outputs. It pushes the regfile write it expects next. After the
    // edge it pops that entry and compares it with the regfile outputs.
    task automatic step(input string tag, input logic r,
                        input logic v0, input logic [4:0] rd0, input logic [31:0] d0, input logic [31:0] pc0,
                        input logic v1, input logic [4:0] rd1, input logic [31:0] d1, input logic [31:0] pc1,
                        input logic ss, input logic [4:0] srd,
                        input logic er0, input logic er1);
        logic [W-1:0] e;
        @(negedge clk);
        rstn = r;
        wb0_valid = v0; wb0_rd = rd0; wb0_data = d0; wb0_pc = pc0;
        wb1_valid = v1; wb1_rd = rd1; wb1_data = d1; wb1_pc = pc1;
        scb_set = ss; scb_rd = srd;
        #1;
        chk({tag, " wb0_ready"}, W'(wb0_ready), W'(er0));
        chk({tag, " wb1_ready"}, W'(wb1_ready), W'(er1));
        if (er1)      exp_q.push_back({rd1 != 5'd0, rd1, d1, pc1});
        else if (er0) exp_q.push_back({rd0 != 5'd0, rd0, d0, pc0});
        else          exp_q.push_back('0);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, " queue empty"}, W'(1), W'(0));
        end else begin
            e = exp_q.pop_front();
            if (e[W-1]) chk({tag, " rf write"}, {rf_we, rf_wa, rf_wd, rf_pc}, e);
            else        chk({tag, " rf_we"}, W'(rf_we), W'(0));
        end
    endtask

    initial begin
        rstn = 1'b0;
        wb0_valid = 0; wb0_rd = 0; wb0_data = 0; wb0_pc = 0;
        wb1_valid = 0; wb1_rd = 0; wb1_data = 0; wb1_pc = 0;
        scb_set = 0; scb_rd = 0;

        // Reset: readies stay low even when both ports request.
        step("rst0", 0, 1, 5'd3, 32'h11, 32'h10, 1, 5'd4, 32'h22, 32'h20, 1, 5'd7, 0, 0);
        step("rst1", 0, 1, 5'd3, 32'h11, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset outputs", {rf_we, rf_wa, rf_wd, rf_pc}, '0);
        chk("reset busy", W'(busy), '0);
        chk("reset starve_cnt", W'(dbg_starve_cnt), '0);

        // Basic port 0 write.
        step("p0 basic", 1, 1, 5'd5, 32'h1234, 32'h100, 0, 0, 0, 0, 0, 0, 1, 0);
        // A write to x0 is accepted but never reaches the regfile.
        step("p0 x0", 1, 1, 5'd0, 32'hFFFF, 32'h104, 0, 0, 0, 0, 0, 0, 1, 0);
        // Port 1 alone, then port 0 back-to-back, then an idle cycle.
        step("p1 alone", 1, 0, 0, 0, 0, 1, 5'd9, 32'hAAAA, 32'h200, 0, 0, 0, 1);
        step("b2b a", 1, 1, 5'd1, 32'hA1, 32'h300, 0, 0, 0, 0, 0, 0, 1, 0);
        step("b2b b", 1, 1, 5'd2, 32'hB2, 32'h304, 0, 0, 0, 0, 0, 0, 1, 0);
        step("idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Starvation: port 0 wins 4 cycles, port 1 the 5th, then port 0 again.
        for (int i = 0; i < 4; i++) begin
            step("starve p0", 1, 1, 5'(10 + i), 32'hC00 + 32'(i), 32'h400 + 32'(4 * i),
                 1, 5'd20, 32'hD00D, 32'h500, 0, 0, 1, 0);
        end
        step("starve p1", 1, 1, 5'd14, 32'hC04, 32'h410, 1, 5'd20, 32'hD00D, 32'h500, 0, 0, 0, 1);
        chk("starve_cnt cleared", W'(dbg_starve_cnt), '0);
        step("after p1", 1, 1, 5'd14, 32'hC04, 32'h410, 1, 5'd21, 32'hE00E, 32'h504, 0, 0, 1, 0);
        step("idle2", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Port 1 is stalled for 3 cycles, then reset is asserted for one cycle.
        for (int i = 0; i < 3; i++) begin
            step("pre-rst", 1, 1, 5'(1 + i), 32'hF0 + 32'(i), 32'h600 + 32'(4 * i),
                 1, 5'd22, 32'h5555, 32'h700, 0, 0, 1, 0);
        end
        step("mid rst", 0, 1, 5'd4, 32'hF3, 32'h60C, 1, 5'd22, 32'h5555, 32'h700, 0, 0, 0, 0);
        chk("rst rf_we", W'(rf_we), '0);
        chk("rst busy", W'(busy), '0);
        chk("rst starve_cnt", W'(dbg_starve_cnt), '0);
        for (int i = 0; i < 4; i++) begin
            step("post-rst p0", 1, 1, 5'(4 + i), 32'hF3 + 32'(i), 32'h60C + 32'(4 * i),
                 1, 5'd22, 32'h5555, 32'h700, 0, 0, 1, 0);
        end
        step("post-rst p1", 1, 1, 5'd8, 32'hF7, 32'h61C, 1, 5'd22, 32'h5555, 32'h700, 0, 0, 0, 1);
        step("idle3", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

`ifdef XGRISCV_RF_SCOREBOARD_EN
        step("scb set7", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 0);
        chk("busy set7", W'(busy), W'(32'h80));
        step("p0 rd7", 1, 1, 5'd7, 32'h77, 32'h800, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("busy p0 no clear", W'(busy), W'(32'h80));
        step("p1 rd7", 1, 0, 0, 0, 0, 1, 5'd7, 32'h78, 32'h804, 0, 0, 0, 1);
        chk("busy clear7", W'(busy), '0);
        step("scb set7 b", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 0);
        step("set+clr7", 1, 0, 0, 0, 0, 1, 5'd7, 32'h79, 32'h808, 1, 5'd7, 0, 1);
        chk("busy set wins", W'(busy), W'(32'h80));
        step("p1 rd7 b", 1, 0, 0, 0, 0, 1, 5'd7, 32'h7A, 32'h80C, 0, 0, 0, 1);
        chk("busy clear7 b", W'(busy), '0);
        step("scb set0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd0, 0, 0);
        chk("busy x0", W'(busy), '0);
`else
        step("scb off set7", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 0);
        chk("busy off", W'(busy), '0);
        step("scb off p1", 1, 0, 0, 0, 0, 1, 5'd7, 32'h78, 32'h804, 1, 5'd7, 0, 1);
        chk("busy off b", W'(busy), '0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter: XLEN, default 32, data/PC width.
REQ-002 Parameter: STARVE_LIMIT, default 4, legal 1..15; consecutive stalled cycles of port 1 before it overrides port 0.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 wb0_valid  input  1  port 0 (pipeline writeback) request.
REQ-006 wb0_rd  input  5  port 0 destination register.
REQ-007 wb0_data  input  XLEN  port 0 write data.
REQ-008 wb0_pc  input  XLEN  port 0 instruction PC.
REQ-009 wb0_ready  output  1  port 0 accept, combinational.
REQ-010 wb1_valid, wb1_rd, wb1_data, wb1_pc, wb1_ready  same widths/directions as port 0; long-latency unit writeback.
REQ-011 scb_set  input  1  long-latency op issued this cycle.
REQ-012 scb_rd  input  5  destination of issued op.
REQ-013 rf_we  output  1  regfile write enable, registered.
REQ-014 rf_wa  output  5  regfile write address, registered.
REQ-015 rf_wd  output  XLEN  regfile write data, registered.
REQ-016 rf_pc  output  XLEN  PC of the write, registered.
REQ-017 busy  output  32  per-register pending-write vector, registered.

Function
REQ-018 Transfer on port N occurs at posedge when wbN_valid && wbN_ready.
REQ-019 Grant: port 1 when wb1_valid && (!wb0_valid || starve_cnt >= STARVE_LIMIT); else port 0 when wb0_valid; else none.
REQ-020 wbN_ready high only for the granted port; never both high in one cycle; ready does not depend on ready of the other port.
REQ-021 Latency: transfer at edge k -> rf_we/rf_wa/rf_wd/rf_pc hold that request from edge k until edge k+1 (one cycle); no transfer -> rf_we=0 next cycle.
REQ-022 Transfer with rd==0: accepted (ready asserted), rf_we=0 the following cycle; rf_wa/rf_wd don't-care.
REQ-023 starve_cnt (4 bits): +1 per cycle with wb1_valid && !wb1_ready, saturating at 15; cleared to 0 on port 1 transfer or when wb1_valid=0.
REQ-024 Arbitration state: NORMAL (starve_cnt < STARVE_LIMIT, port 0 priority) -> STARVED (count reached, port 1 priority) -> NORMAL after port 1 transfer.
REQ-025 Back-to-back transfers every cycle supported; no bubble required between grants.
REQ-026 Requesters hold valid, rd, data, pc stable until transfer; arbiter behaviour with unstable requests is undefined.

Reset
REQ-027 rstn=0 at posedge: rf_we=0, rf_wa=0, rf_wd=0, rf_pc=0, starve_cnt=0, busy=0.
REQ-028 While rstn=0, wb0_ready=wb1_ready=0; in-flight requests are dropped, not replayed.
REQ-029 Reset asserted mid-transfer: the write registered in the prior cycle still completes its one cycle of rf_we only if rstn was high at that capturing edge; the reset edge forces rf_we=0.

Configuration
REQ-030 Macro XGRISCV_RF_SCOREBOARD_EN: defined -> busy vector maintained per REQ-031..033; undefined -> busy tied to 0 and scb_set/scb_rd ignored, no scoreboard flops.
REQ-031 scb_set with scb_rd!=0 sets busy[scb_rd] at next edge.
REQ-032 Port 1 transfer with wb1_rd!=0 clears busy[wb1_rd] at next edge; port 0 transfers never change busy.
REQ-033 Same-edge set and clear on same index: set wins; busy[0] always 0.

Verification
REQ-034 wb0_valid=1, rd=5, data=0x1234, pc=0x100, wb1 idle -> wb0_ready=1 same cycle; next cycle rf_we=1, rf_wa=5, rf_wd=0x1234, rf_pc=0x100.
REQ-035 wb0_valid and wb1_valid held high, STARVE_LIMIT=4 -> port 0 granted cycles 0-3, port 1 granted cycle 4, starve_cnt returns to 0, port 0 granted cycle 5.
REQ-036 wb0_valid=1 rd=0 data=0xFFFF -> wb0_ready=1, next cycle rf_we=0.
REQ-037 (scoreboard on) scb_set rd=7 -> busy[7]=1; later wb1 transfer rd=7 -> busy[7]=0 one edge later; simultaneous scb_set rd=7 and wb1 rd=7 -> busy[7] stays 1; scb_set rd=0 -> busy=0.
REQ-038 Port 1 stalled 3 cycles then rstn=0 one cycle -> rf_we=0, busy=0, starve_cnt=0, both readies 0; after release port 0 wins again for 4 cycles.
REQ-039 (scoreboard off) scb_set rd=7 -> busy remains 0x00000000.
